// File: rtl/pong_match_ctrl.sv
// Match sequencer for a Pong game: start-byte handling, timed serve pause,
// per-player BCD scoring and winner detection. All outputs come straight from flops.
module pong_match_ctrl #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          WIN_SCORE   = 9,
  parameter int          SERVE_CLKS  = 25000000,
  parameter logic [7:0]  START_BYTE  = 8'h20
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic                       i_RX_DV,
  input  logic [7:0]                 i_RX_Byte,
  input  logic                       i_Point_Valid,
  input  logic [1:0]                 i_Point_Player,
  output logic [1:0]                 o_State,
  output logic                       o_Game_Active,
  output logic                       o_Ball_Release,
  output logic                       o_Game_Over,
  output logic [1:0]                 o_Winner,
  output logic [NUM_PLAYERS*8-1:0]   o_Score_BCD
);

  localparam int               CNT_W    = $clog2(SERVE_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_CLKS - 1);
  localparam logic [7:0]       WIN_BCD  = 8'(((WIN_SCORE / 10) * 16) + (WIN_SCORE % 10));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Saturating two-digit BCD increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [NUM_PLAYERS*8-1:0]  score_q, score_d;
  logic [1:0]                winner_q, winner_d;
  logic                      release_q, release_d;
  logic                      active_q, over_q;
  logic                      start_evt, point_ok;
  logic [7:0]                cur_score, new_score;

  assign start_evt = i_RX_DV && (i_RX_Byte == START_BYTE);
  assign point_ok  = i_Point_Valid && (int'(i_Point_Player) < NUM_PLAYERS);
  assign new_score = bcd_inc(cur_score);

  always_comb begin
    cur_score = 8'h00;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (i_Point_Player == 2'(p))
        cur_score = score_q[8*p +: 8];
  end

  // A point in PLAY takes priority over a start byte, which is ignored there anyway.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    score_d   = score_q;
    winner_d  = winner_q;
    release_d = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_evt) begin
          state_d  = SERVE;
          count_d  = '0;
          score_d  = '0;
          winner_d = 2'd0;
        end
      end
      SERVE: begin
        if (count_q == CNT_LAST) begin
          state_d   = PLAY;
          count_d   = '0;
          release_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      PLAY: begin
        if (point_ok) begin
          for (int p = 0; p < NUM_PLAYERS; p++)
            if (i_Point_Player == 2'(p))
              score_d[8*p +: 8] = new_score;
          if (new_score == WIN_BCD) begin
            state_d  = OVER;
            winner_d = i_Point_Player;
          end else begin
            state_d = SERVE;
            count_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      count_q   <= '0;
      score_q   <= '0;
      winner_q  <= 2'd0;
      release_q <= 1'b0;
      active_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      score_q   <= score_d;
      winner_q  <= winner_d;
      release_q <= release_d;
      active_q  <= (state_d == SERVE) || (state_d == PLAY);
      over_q    <= (state_d == OVER);
    end
  end

  assign o_State        = state_q;
  assign o_Game_Active  = active_q;
  assign o_Ball_Release = release_q;
  assign o_Game_Over    = over_q;
  assign o_Winner       = winner_q;
  assign o_Score_BCD    = score_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: two instances (WIN_SCORE 3 and 12) share one stimulus
// stream and are checked every cycle against a decimal-arithmetic match model.
module tb_pong_match_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        pt_valid;
  logic [1:0]  pt_player;

  logic [1:0]  state_a, winner_a, state_b, winner_b;
  logic        active_a, rel_a, over_a, active_b, rel_b, over_b;
  logic [15:0] score_a, score_b;

  int n_checks = 0;
  int n_fail   = 0;

  int m_state [2];
  int m_cnt   [2];
  int m_score [2][2];
  int m_win   [2];
  int m_rel   [2];
  int target  [2] = '{3, 12};

  always #5 clk = ~clk;

  pong_match_ctrl #(.NUM_PLAYERS(2), .WIN_SCORE(3), .SERVE_CLKS(4), .START_BYTE(8'h20)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .i_Point_Valid(pt_valid), .i_Point_Player(pt_player),
    .o_State(state_a), .o_Game_Active(active_a), .o_Ball_Release(rel_a),
    .o_Game_Over(over_a), .o_Winner(winner_a), .o_Score_BCD(score_a)
  );

  pong_match_ctrl #(.NUM_PLAYERS(2), .WIN_SCORE(12), .SERVE_CLKS(4), .START_BYTE(8'h20)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .i_Point_Valid(pt_valid), .i_Point_Player(pt_player),
    .o_State(state_b), .o_Game_Active(active_b), .o_Ball_Release(rel_b),
    .o_Game_Over(over_b), .o_Winner(winner_b), .o_Score_BCD(score_b)
  );

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) * 16) + (s % 10));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_cnt[k] = 0; m_win[k] = 0; m_rel[k] = 0;
      m_score[k][0] = 0; m_score[k][1] = 0;
    end
  endtask

  // Match rules: 0=IDLE 1=SERVE 2=PLAY 3=OVER; scores held as plain decimal.
  task automatic model_clock(input logic dv, input logic [7:0] b, input logic pv, input logic [1:0] pp);
    bit start;
    int s;
    start = dv && (b == 8'h20);
    for (int k = 0; k < 2; k++) begin
      m_rel[k] = 0;
      case (m_state[k])
        0, 3: if (start) begin
          m_state[k] = 1; m_cnt[k] = 0; m_win[k] = 0;
          m_score[k][0] = 0; m_score[k][1] = 0;
        end
        1: if (m_cnt[k] == 3) begin
          m_state[k] = 2; m_cnt[k] = 0; m_rel[k] = 1;
        end else m_cnt[k]++;
        default: if (pv && pp < 2) begin
          s = m_score[k][pp] + 1;
          if (s > 99) s = 99;
          m_score[k][pp] = s;
          if (s == target[k]) begin
            m_state[k] = 3; m_win[k] = int'(pp);
          end else begin
            m_state[k] = 1; m_cnt[k] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_inst(input int k, input logic [1:0] s, input logic a, input logic r,
                            input logic o, input logic [1:0] w, input logic [15:0] sc);
    checkOutput($sformatf("i%0d_state", k), 32'(s), 32'(m_state[k]));
    checkOutput($sformatf("i%0d_active", k), 32'(a), 32'(m_state[k] == 1 || m_state[k] == 2));
    checkOutput($sformatf("i%0d_release", k), 32'(r), 32'(m_rel[k]));
    checkOutput($sformatf("i%0d_over", k), 32'(o), 32'(m_state[k] == 3));
    checkOutput($sformatf("i%0d_winner", k), 32'(w), 32'(m_win[k]));
    checkOutput($sformatf("i%0d_score", k), 32'(sc),
                32'({to_bcd(m_score[k][1]), to_bcd(m_score[k][0])}));
  endtask

  task automatic check_all();
    check_inst(0, state_a, active_a, rel_a, over_a, winner_a, score_a);
    check_inst(1, state_b, active_b, rel_b, over_b, winner_b, score_b);
  endtask

  // Called at a falling edge; drives one cycle of inputs and checks at the next falling edge.
  task automatic applyStimulus(input logic dv, input logic [7:0] b, input logic pv, input logic [1:0] pp);
    rx_dv = dv; rx_byte = b; pt_valid = pv; pt_player = pp;
    @(posedge clk);
    model_clock(dv, b, pv, pp);
    @(negedge clk);
    rx_dv = 1'b0; rx_byte = 8'h00; pt_valid = 1'b0; pt_player = 2'd0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 2'd0);
  endtask

  task automatic start_byte();
    applyStimulus(1'b1, 8'h20, 1'b0, 2'd0);
  endtask

  task automatic point(input logic [1:0] pp);
    applyStimulus(1'b0, 8'h00, 1'b1, pp);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rx_dv = 1'b0; rx_byte = 8'h00; pt_valid = 1'b0; pt_player = 2'd0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Non-start byte ignored, then start, serve pause and release
    applyStimulus(1'b1, 8'h41, 1'b0, 2'd0);
    checkOutput("ignore_41", 32'(state_a), 32'd0);
    start_byte();
    checkOutput("serve_after_start", 32'(state_a), 32'd1);
    idle(4);
    checkOutput("release_pulse", 32'({rel_a, state_a}), 32'({1'b1, 2'd2}));

    point(2'd1);
    checkOutput("p1_score", 32'(score_a), 32'h0100);
    idle(4);
    checkOutput("second_release", 32'(rel_a), 32'd1);

    // Out-of-range indices and a point during serve are ignored
    point(2'd2);
    point(2'd3);
    checkOutput("bad_index_state", 32'(state_a), 32'd2);
    point(2'd0);
    point(2'd0);
    checkOutput("serve_point_ignored", 32'(score_a), 32'h0101);
    idle(4);

    // Fresh match: P0 wins at 3, later points ignored, restart clears
    async_reset();
    start_byte();
    idle(4);
    for (int i = 0; i < 3; i++) begin
      point(2'd0);
      idle(4);
    end
    checkOutput("win_summary", 32'({state_a, over_a, winner_a, score_a}),
                32'({2'd3, 1'b1, 2'd0, 16'h0003}));
    point(2'd1);
    checkOutput("over_hold", 32'(score_a), 32'h0003);
    start_byte();
    checkOutput("restart", 32'({state_a, score_a}), 32'({2'd1, 16'h0000}));

    // BCD carry on the WIN_SCORE=12 instance
    async_reset();
    start_byte();
    idle(4);
    for (int i = 1; i <= 12; i++) begin
      point(2'd1);
      if (i == 9)  checkOutput("bcd_09", 32'(score_b[15:8]), 32'h09);
      if (i == 10) checkOutput("bcd_carry_10", 32'(score_b[15:8]), 32'h10);
      idle(4);
    end
    checkOutput("win12", 32'({score_b[15:8], over_b, winner_b}), 32'({8'h12, 1'b1, 2'd1}));

    // Reset mid-PLAY, then only a start byte resumes
    async_reset();
    start_byte();
    idle(4);
    async_reset();
    checkOutput("reset_outputs", 32'({state_a, active_a, rel_a, over_a, winner_a, score_a}), 32'd0);
    idle(6);
    checkOutput("stay_idle", 32'(state_a), 32'd0);
    start_byte();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       dv, pv;
      logic [7:0] b;
      logic [1:0] pp;
      dv = ($urandom_range(0, 5) == 0);
      b  = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'($urandom_range(0, 255));
      pv = ($urandom_range(0, 2) == 0);
      pp = 2'($urandom_range(0, 3));
      applyStimulus(dv, b, pv, pp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
